pc_sequencer: RTL and testbench

Parametrised program-counter sequencer for the next-generation MCU core. It generalises the fixed 8-bit PC with address width, reset vector and a hardware return-address stack. It adds jump, call/return, skip and stall control, plus sticky stack-error flags. It sits between the instruction decoder (control requests in) and instruction memory (o_pc out).

---
 rtl/pc_sequencer.sv | 119 +++++++++++
 tb/tb_pc_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with a hardware return-address stack.
// Handles increment, skip, jump, call/return and stall, with sticky stack-error flags.
module pc_sequencer #(
  parameter int unsigned           ADDR_WIDTH   = 8,
  parameter int unsigned           STACK_DEPTH  = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                               Clk,
  input  logic                               Reset,
  input  logic                               resetPC,
  input  logic                               i_stall,
  input  logic                               i_jump_valid,
  input  logic                               i_call_valid,
  input  logic                               i_ret_valid,
  input  logic                               i_skip,
  input  logic [ADDR_WIDTH-1:0]              i_target,
  output logic [ADDR_WIDTH-1:0]              o_pc,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   o_stack_count,
  output logic                               o_overflow,
  output logic                               o_underflow
);

  localparam int unsigned CountWidth = $clog2(STACK_DEPTH + 1);

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [CountWidth-1:0] count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic [ADDR_WIDTH-1:0] stack_q [STACK_DEPTH];

  logic [ADDR_WIDTH-1:0] pc_inc;
  logic [ADDR_WIDTH-1:0] pc_skip;
  logic [ADDR_WIDTH-1:0] stack_top;
  logic                  stack_full;
  logic                  stack_empty;
  logic                  push;

  assign pc_inc      = pc_q + ADDR_WIDTH'(1);
  assign pc_skip     = pc_q + ADDR_WIDTH'(2);
  assign stack_full  = (count_q == CountWidth'(STACK_DEPTH));
  assign stack_empty = (count_q == '0);

  // Entry count_q-1 is the most recent return address.
  always_comb begin
    stack_top = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (count_q == CountWidth'(i + 1)) begin
        stack_top = stack_q[i];
      end
    end
  end

  // Request arbitration: resetPC > stall > ret > call > jump > skip > increment.
  always_comb begin
    pc_d        = pc_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    push        = 1'b0;

    if (resetPC) begin
      pc_d    = RESET_VECTOR;
      count_d = '0;
    end else if (i_stall) begin
      pc_d = pc_q;
    end else if (i_ret_valid) begin
      if (stack_empty) begin
        underflow_d = 1'b1;
        pc_d        = pc_inc;
      end else begin
        pc_d    = stack_top;
        count_d = count_q - CountWidth'(1);
      end
    end else if (i_call_valid) begin
      pc_d = i_target;
      if (stack_full) begin
        overflow_d = 1'b1;
      end else begin
        push    = 1'b1;
        count_d = count_q + CountWidth'(1);
      end
    end else if (i_jump_valid) begin
      pc_d = i_target;
    end else if (i_skip) begin
      pc_d = pc_skip;
    end else begin
      pc_d = pc_inc;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc_q        <= RESET_VECTOR;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Stack storage needs no reset; the count marks which entries are valid.
  always_ff @(posedge Clk) begin
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (!Reset && push && (count_q == CountWidth'(i))) begin
        stack_q[i] <= pc_inc;
      end
    end
  end

  assign o_pc          = pc_q;
  assign o_stack_count = count_q;
  assign o_overflow    = overflow_q;
  assign o_underflow   = underflow_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized bench for pc_sequencer: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_pc_sequencer;

  localparam int unsigned AW    = 8;
  localparam int unsigned DEPTH = 4;
  localparam logic [7:0]  RV    = 8'h10;

  logic       Clk = 1'b0;
  logic       Reset, resetPC, i_stall, i_jump_valid, i_call_valid, i_ret_valid, i_skip;
  logic [7:0] i_target;
  logic [7:0] o_pc;
  logic [2:0] o_stack_count;
  logic       o_overflow, o_underflow;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  int m_pc;
  int m_stk[$];
  bit m_ovf, m_unf;
  bit m_valid = 1'b0;

  pc_sequencer #(
    .ADDR_WIDTH  (AW),
    .STACK_DEPTH (DEPTH),
    .RESET_VECTOR(RV)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .resetPC      (resetPC),
    .i_stall      (i_stall),
    .i_jump_valid (i_jump_valid),
    .i_call_valid (i_call_valid),
    .i_ret_valid  (i_ret_valid),
    .i_skip       (i_skip),
    .i_target     (i_target),
    .o_pc         (o_pc),
    .o_stack_count(o_stack_count),
    .o_overflow   (o_overflow),
    .o_underflow  (o_underflow)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: apply the priority rules to the inputs sampled at this edge.
  always @(posedge Clk) begin
    if (Reset) begin
      m_pc = RV; m_stk.delete(); m_ovf = 0; m_unf = 0; m_valid = 1;
    end else if (resetPC) begin
      m_pc = RV; m_stk.delete();
    end else if (i_stall) begin
      m_pc = m_pc;
    end else if (i_ret_valid) begin
      if (m_stk.size() == 0) begin
        m_unf = 1; m_pc = (m_pc + 1) % 256;
      end else begin
        m_pc = m_stk.pop_back();
      end
    end else if (i_call_valid) begin
      if (m_stk.size() == DEPTH) m_ovf = 1;
      else m_stk.push_back((m_pc + 1) % 256);
      m_pc = int'(i_target);
    end else if (i_jump_valid) begin
      m_pc = int'(i_target);
    end else if (i_skip) begin
      m_pc = (m_pc + 2) % 256;
    end else begin
      m_pc = (m_pc + 1) % 256;
    end
  end

  // Compare process, away from the active edge.
  always @(negedge Clk) begin
    if (m_valid) begin
      check("model_pc", 32'(o_pc), 32'(m_pc));
      check("model_count", 32'(o_stack_count), 32'(m_stk.size()));
      check("model_ovf", 32'(o_overflow), 32'(m_ovf));
      check("model_unf", 32'(o_underflow), 32'(m_unf));
    end
  end

  task automatic idle();
    Reset = 0; resetPC = 0; i_stall = 0; i_jump_valid = 0; i_call_valid = 0;
    i_ret_valid = 0; i_skip = 0; i_target = '0;
  endtask

  task automatic cycle();
    @(posedge Clk);
    #2;
  endtask

  task automatic jump_to(input logic [7:0] t);
    idle(); i_jump_valid = 1; i_target = t;
    cycle();
    idle();
  endtask

  initial begin
    idle();
    Reset = 1;
    repeat (3) cycle();
    check("reset_pc", 32'(o_pc), 32'h10);
    check("reset_count", 32'(o_stack_count), 0);
    check("reset_flags", {30'd0, o_overflow, o_underflow}, 0);
    Reset = 0;
    cycle(); check("inc_11", 32'(o_pc), 32'h11);
    cycle(); check("inc_12", 32'(o_pc), 32'h12);

    // Wrap
    jump_to(8'hFE);
    cycle(); check("wrap_ff", 32'(o_pc), 32'hFF);
    cycle(); check("wrap_00", 32'(o_pc), 32'h00);
    jump_to(8'hFF);
    i_skip = 1; cycle(); idle();
    check("skip_wrap_01", 32'(o_pc), 32'h01);

    // Call / return
    jump_to(8'h20);
    i_call_valid = 1; i_target = 8'h80; cycle(); idle();
    check("call_pc", 32'(o_pc), 32'h80);
    check("call_count", 32'(o_stack_count), 1);
    repeat (3) cycle();
    check("run_83", 32'(o_pc), 32'h83);
    i_ret_valid = 1; cycle(); idle();
    check("ret_pc", 32'(o_pc), 32'h21);
    check("ret_count", 32'(o_stack_count), 0);

    // Nested calls to overflow, then unwind to underflow
    jump_to(8'h30);
    for (int k = 0; k < 5; k++) begin
      i_call_valid = 1; i_target = 8'hA0 + 8'(k); cycle();
    end
    idle();
    check("ovf_pc", 32'(o_pc), 32'hA4);
    check("ovf_count", 32'(o_stack_count), 4);
    check("ovf_flag", 32'(o_overflow), 1);
    i_ret_valid = 1; cycle(); check("pop_a3", 32'(o_pc), 32'hA3);
    cycle(); check("pop_a2", 32'(o_pc), 32'hA2);
    cycle(); check("pop_a1", 32'(o_pc), 32'hA1);
    cycle(); check("pop_31", 32'(o_pc), 32'h31);
    cycle(); idle();
    check("unf_pc", 32'(o_pc), 32'h32);
    check("unf_flag", 32'(o_underflow), 1);
    check("unf_count", 32'(o_stack_count), 0);

    // Priority: call beats jump and skip; stall beats call
    jump_to(8'h40);
    i_call_valid = 1; i_jump_valid = 1; i_skip = 1; i_target = 8'h90; cycle(); idle();
    check("prio_pc", 32'(o_pc), 32'h90);
    check("prio_count", 32'(o_stack_count), 1);
    i_stall = 1; i_call_valid = 1; i_target = 8'h55; cycle(); idle();
    check("stall_pc", 32'(o_pc), 32'h90);
    check("stall_count", 32'(o_stack_count), 1);
    i_ret_valid = 1; cycle(); idle();
    check("prio_top", 32'(o_pc), 32'h41);

    // resetPC during a call keeps flags; Reset clears them
    i_call_valid = 1; i_target = 8'h60; cycle();
    i_target = 8'h70; cycle(); idle();
    check("two_count", 32'(o_stack_count), 2);
    resetPC = 1; i_call_valid = 1; i_target = 8'h77; cycle(); idle();
    check("rpc_pc", 32'(o_pc), 32'h10);
    check("rpc_count", 32'(o_stack_count), 0);
    check("rpc_ovf_kept", 32'(o_overflow), 1);
    Reset = 1; cycle(); idle();
    check("rst_ovf_clear", 32'(o_overflow), 0);
    check("rst_unf_clear", 32'(o_underflow), 0);

    // Random phase
    for (int n = 0; n < 3000; n++) begin
      Reset        = ($urandom_range(0, 99) == 0);
      resetPC      = ($urandom_range(0, 49) == 0);
      i_stall      = ($urandom_range(0, 7) == 0);
      i_ret_valid  = ($urandom_range(0, 4) == 0);
      i_call_valid = ($urandom_range(0, 3) == 0);
      i_jump_valid = ($urandom_range(0, 5) == 0);
      i_skip       = ($urandom_range(0, 3) == 0);
      i_target     = 8'($urandom_range(0, 255));
      cycle();
    end
    idle();
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
